// File: rtl/ring_sequencer.sv
// Control sequencer for an N_PE-element systolic ring: holds the PE coefficients,
// clears and loads the ring, streams samples in and captures results in order.
module ring_sequencer #(
  parameter int N_PE = 4,
  parameter int W    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    coef_wr,
  input  logic [$clog2(N_PE)-1:0] coef_idx,
  input  logic [W-1:0]            coef_data,
  input  logic [W-1:0]            seed,
  input  logic [7:0]              len,
  input  logic                    start,
  input  logic [W-1:0]            x_in,
  input  logic                    x_in_valid,
  output logic                    x_in_ready,
  output logic                    pe_clear,
  output logic                    pe_load,
  output logic [W-1:0]            a,
  output logic [W-1:0]            x_init,
  output logic [W-1:0]            x,
  input  logic [W-1:0]            y,
  output logic [W-1:0]            res,
  output logic                    res_valid,
  output logic                    busy,
  output logic                    done
);

  localparam int            IW       = $clog2(N_PE);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_PE - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t          state_q;
  logic [W-1:0]    coef_q [N_PE];
  logic [W-1:0]    seed_q;
  logic [7:0]      len_q;
  logic [7:0]      cnt_q;
  logic [IW-1:0]   ld_idx_q;
  logic [IW-1:0]   ld_idx_d;
  logic [N_PE-1:0] vld_sr_q;

  logic            accept_s;
  logic            cnt_last_s;
  logic            coef_we_s;
  logic            sr_empty_s;

  // Handshake, counter and pipeline status decode
  always_comb begin
    accept_s   = x_in_valid & x_in_ready;
    ld_idx_d   = ld_idx_q + IW'(1);
    cnt_last_s = (cnt_q == (len_q - 8'd1));
    coef_we_s  = coef_wr & (state_q == S_IDLE);
    sr_empty_s = (vld_sr_q == '0);
  end

  // Coefficient storage; slots beyond N_PE-1 are silently ignored
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_PE; i++) begin
        coef_q[i] <= '0;
      end
    end else if (coef_we_s) begin
      for (int i = 0; i < N_PE; i++) begin
        if (coef_idx == IW'(i)) begin
          coef_q[i] <= coef_data;
        end
      end
    end
  end

  // Sample register, valid-tag shift register and result capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x         <= '0;
      vld_sr_q  <= '0;
      res       <= '0;
      res_valid <= 1'b0;
    end else begin
      x         <= accept_s ? x_in : '0;
      vld_sr_q  <= {vld_sr_q[N_PE-2:0], accept_s};
      res_valid <= vld_sr_q[N_PE-1];
      if (vld_sr_q[N_PE-1]) begin
        res <= y;
      end
    end
  end

  // Run sequencer; every control output is set on the edge entering its state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      seed_q     <= '0;
      len_q      <= 8'd0;
      cnt_q      <= 8'd0;
      ld_idx_q   <= '0;
      x_in_ready <= 1'b0;
      pe_clear   <= 1'b0;
      pe_load    <= 1'b0;
      a          <= '0;
      x_init     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && (len != 8'd0)) begin
            len_q    <= len;
            seed_q   <= seed;
            cnt_q    <= 8'd0;
            state_q  <= S_CLEAR;
            pe_clear <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_CLEAR: begin
          state_q  <= S_LOAD;
          pe_clear <= 1'b0;
          pe_load  <= 1'b1;
          ld_idx_q <= '0;
          a        <= coef_q[0];
          x_init   <= seed_q;
        end
        S_LOAD: begin
          if (ld_idx_q == LAST_IDX) begin
            state_q    <= S_RUN;
            pe_load    <= 1'b0;
            a          <= '0;
            x_init     <= '0;
            x_in_ready <= 1'b1;
          end else begin
            ld_idx_q <= ld_idx_d;
            a        <= coef_q[ld_idx_d];
          end
        end
        S_RUN: begin
          // cnt_q counts accepted samples and never passes len_q-1, so 255 needs no wrap
          if (accept_s) begin
            if (cnt_last_s) begin
              state_q    <= S_DRAIN;
              x_in_ready <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        S_DRAIN: begin
          if (sr_empty_s) begin
            state_q <= S_DONE;
            done    <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_q    <= S_IDLE;
          x_in_ready <= 1'b0;
          pe_clear   <= 1'b0;
          pe_load    <= 1'b0;
          a          <= '0;
          x_init     <= '0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ring_sequencer.sv
// Directed self-checking bench for ring_sequencer (N_PE=4, W=16). The ring is
// modelled as a 3-stage delay of x followed by y = x ^ 16'h5A00.
module tb_ring_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        coef_wr = 1'b0;
  logic [1:0]  coef_idx = 2'd0;
  logic [15:0] coef_data = 16'h0000;
  logic [15:0] seed = 16'h0000;
  logic [7:0]  len = 8'd0;
  logic        start = 1'b0;
  logic [15:0] x_in = 16'h0000;
  logic        x_in_valid = 1'b0;
  logic        x_in_ready;
  logic        pe_clear;
  logic        pe_load;
  logic [15:0] a;
  logic [15:0] x_init;
  logic [15:0] x;
  logic [15:0] y;
  logic [15:0] res;
  logic        res_valid;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail = 0;

  logic [15:0] p1 = 16'h0000;
  logic [15:0] p2 = 16'h0000;
  logic [15:0] p3 = 16'h0000;

  ring_sequencer #(.N_PE(4), .W(16)) dut (
    .clk(clk), .reset(reset), .coef_wr(coef_wr), .coef_idx(coef_idx),
    .coef_data(coef_data), .seed(seed), .len(len), .start(start),
    .x_in(x_in), .x_in_valid(x_in_valid), .x_in_ready(x_in_ready),
    .pe_clear(pe_clear), .pe_load(pe_load), .a(a), .x_init(x_init),
    .x(x), .y(y), .res(res), .res_valid(res_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    p1 <= x;
    p2 <= p1;
    p3 <= p2;
  end
  assign y = p3 ^ 16'h5A00;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [7:0] l, input logic [15:0] s);
    len = l; seed = s; start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    n_checks++; if ({busy, x_in_ready, pe_clear, pe_load, res_valid, done} !== 6'b000000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 000000", {busy, x_in_ready, pe_clear, pe_load, res_valid, done});
    end
    n_checks++; if ({a, x_init, x, res} !== 64'h0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", {a, x_init, x, res});
    end
    reset = 1'b1;
    step();
    n_checks++; if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_coef_load();
    for (int k = 0; k < 4; k++) begin
      coef_wr = 1'b1; coef_idx = 2'(k); coef_data = 16'(k + 1);
      step();
    end
    coef_wr = 1'b0;
    len = 8'd4; seed = 16'h0001; start = 1'b1;
    step();
    start = 1'b0;
    n_checks++; if ({pe_clear, pe_load, busy} !== 3'b101) begin
      n_fail++; $display("FAIL clear_cycle: got clr/ld/busy=%b expected 101", {pe_clear, pe_load, busy});
    end
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++; if ({pe_clear, pe_load, x_in_ready} !== 3'b010) begin
        n_fail++; $display("FAIL load_ctrl[%0d]: got clr/ld/rdy=%b expected 010", k, {pe_clear, pe_load, x_in_ready});
      end
      n_checks++; if (a !== 16'(k + 1)) begin
        n_fail++; $display("FAIL load_a[%0d]: got %h expected %h", k, a, 16'(k + 1));
      end
      n_checks++; if (x_init !== 16'h0001) begin
        n_fail++; $display("FAIL load_xinit[%0d]: got %h expected 0001", k, x_init);
      end
    end
    step();
    n_checks++; if ({pe_load, x_in_ready, a} !== {2'b01, 16'h0000}) begin
      n_fail++; $display("FAIL load_to_run: got ld=%b rdy=%b a=%h expected ld=0 rdy=1 a=0000", pe_load, x_in_ready, a);
    end
    x_in_valid = 1'b1; x_in = 16'h0000;
    repeat (4) step();
    x_in_valid = 1'b0;
    repeat (8) step();
    n_checks++; if (busy !== 1'b0) begin
      n_fail++; $display("FAIL coef_run_end: busy got %b expected 0", busy);
    end
  endtask

  task automatic test_streaming();
    logic [15:0] e_res;
    start_run(8'd4, 16'h0000);
    for (int j = 0; j < 12; j++) begin
      x_in_valid = 1'b1; x_in = 16'(j + 1);
      step();
      n_checks++; if (x !== ((j < 4) ? 16'(j + 1) : 16'h0000)) begin
        n_fail++; $display("FAIL stream_x[%0d]: got %h expected %h", j, x, (j < 4) ? 16'(j + 1) : 16'h0000);
      end
      n_checks++; if (x_in_ready !== (j < 3)) begin
        n_fail++; $display("FAIL stream_ready[%0d]: got %b expected %b", j, x_in_ready, (j < 3));
      end
      n_checks++; if (res_valid !== ((j >= 4) && (j <= 7))) begin
        n_fail++; $display("FAIL stream_rv[%0d]: got %b expected %b", j, res_valid, (j >= 4) && (j <= 7));
      end
      n_checks++; if ({done, busy} !== {(j == 8), (j <= 8)}) begin
        n_fail++; $display("FAIL stream_done_busy[%0d]: got %b expected %b", j, {done, busy}, {(j == 8), (j <= 8)});
      end
      if (j >= 4) begin
        e_res = (j <= 7) ? (16'(j - 3) ^ 16'h5A00) : 16'h5A04;
        n_checks++; if (res !== e_res) begin
          n_fail++; $display("FAIL stream_res[%0d]: got %h expected %h", j, res, e_res);
        end
      end
    end
    x_in_valid = 1'b0;
  endtask

  task automatic test_gaps();
    logic [5:0]  pat;
    logic        vpat [14];
    logic        acc [14];
    logic        rdy [14];
    logic        erv [14];
    logic [15:0] expq [$];
    logic [15:0] e_res;
    logic        seen;
    int          cnt;
    int          last_acc;
    pat = 6'b101101;
    cnt = 0; last_acc = 0; seen = 1'b0; e_res = 16'h0000;
    for (int j = 0; j < 14; j++) erv[j] = 1'b0;
    for (int j = 0; j < 14; j++) begin
      vpat[j] = (j < 6) ? pat[j] : 1'b1;
      acc[j] = vpat[j] && (cnt < 4);
      if (acc[j]) begin
        cnt++; last_acc = j;
        if (j + 4 < 14) erv[j + 4] = 1'b1;
      end
      rdy[j] = (cnt < 4);
    end
    start_run(8'd4, 16'h0003);
    for (int j = 0; j < 14; j++) begin
      x_in_valid = vpat[j]; x_in = 16'h0010 + 16'(j);
      if (acc[j]) expq.push_back((16'h0010 + 16'(j)) ^ 16'h5A00);
      step();
      n_checks++; if (x !== (acc[j] ? (16'h0010 + 16'(j)) : 16'h0000)) begin
        n_fail++; $display("FAIL gap_x[%0d]: got %h expected %h", j, x, acc[j] ? (16'h0010 + 16'(j)) : 16'h0000);
      end
      n_checks++; if ({res_valid, x_in_ready, done} !== {erv[j], rdy[j], (j == last_acc + 5)}) begin
        n_fail++; $display("FAIL gap_rv_rdy_done[%0d]: got %b expected %b", j,
                           {res_valid, x_in_ready, done}, {erv[j], rdy[j], (j == last_acc + 5)});
      end
      if (erv[j] && (expq.size() > 0)) begin
        e_res = expq.pop_front(); seen = 1'b1;
      end
      if (seen) begin
        n_checks++; if (res !== e_res) begin
          n_fail++; $display("FAIL gap_res[%0d]: got %h expected %h", j, res, e_res);
        end
      end
    end
    x_in_valid = 1'b0;
    n_checks++; if ((busy !== 1'b0) || (expq.size() != 0)) begin
      n_fail++; $display("FAIL gap_end: busy=%b pending=%0d expected busy=0 pending=0", busy, expq.size());
    end
  endtask

  task automatic test_illegal();
    len = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    n_checks++; if ({busy, pe_clear} !== 2'b00) begin
      n_fail++; $display("FAIL len0_start: busy/clr got %b expected 00", {busy, pe_clear});
    end
    step();
    n_checks++; if (busy !== 1'b0) begin
      n_fail++; $display("FAIL len0_stay_idle: busy got %b expected 0", busy);
    end
    start_run(8'd1, 16'h0007);
    coef_wr = 1'b1; coef_idx = 2'd0; coef_data = 16'hBEEF;
    x_in_valid = 1'b1; x_in = 16'h0030;
    step();
    coef_wr = 1'b0; x_in_valid = 1'b0;
    repeat (8) step();
    n_checks++; if (busy !== 1'b0) begin
      n_fail++; $display("FAIL illegal_run_end: busy got %b expected 0", busy);
    end
    len = 8'd1; seed = 16'h0009; start = 1'b1;
    step();
    start = 1'b0;
    step();
    n_checks++; if ({a, x_init} !== {16'h0001, 16'h0009}) begin
      n_fail++; $display("FAIL run_coef_wr_ignored: got a=%h xi=%h expected a=0001 xi=0009", a, x_init);
    end
    step();
    n_checks++; if (a !== 16'h0002) begin
      n_fail++; $display("FAIL second_slot: got %h expected 0002", a);
    end
    repeat (3) step();
    x_in_valid = 1'b1; x_in = 16'h0031;
    step();
    x_in_valid = 1'b0;
    repeat (8) step();
  endtask

  task automatic test_reset_midrun();
    int n_rv;
    int n_done;
    n_rv = 0; n_done = 0;
    start_run(8'd4, 16'h0000);
    x_in_valid = 1'b1; x_in = 16'h0021;
    step();
    x_in = 16'h0022;
    step();
    x_in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    n_checks++; if ({busy, x_in_ready, pe_clear, pe_load, res_valid, done} !== 6'b000000) begin
      n_fail++; $display("FAIL midrst_ctrl: got %b expected 000000", {busy, x_in_ready, pe_clear, pe_load, res_valid, done});
    end
    n_checks++; if ({a, x_init, x, res} !== 64'h0) begin
      n_fail++; $display("FAIL midrst_data: got %h expected 0", {a, x_init, x, res});
    end
    repeat (2) step();
    reset = 1'b1;
    for (int j = 0; j < 12; j++) begin
      step();
      if (res_valid === 1'b1) n_rv++;
      if (done === 1'b1) n_done++;
    end
    n_checks++; if ({n_rv, n_done} !== {32'd0, 32'd0}) begin
      n_fail++; $display("FAIL midrst_aftermath: rv=%0d done=%0d expected 0 and 0", n_rv, n_done);
    end
    len = 8'd1; seed = 16'h0000; start = 1'b1;
    step();
    start = 1'b0;
    step();
    n_checks++; if ({pe_load, a} !== {1'b1, 16'h0000}) begin
      n_fail++; $display("FAIL midrst_coef_cleared: got ld=%b a=%h expected ld=1 a=0000", pe_load, a);
    end
    repeat (4) step();
    x_in_valid = 1'b1; x_in = 16'h0040;
    step();
    x_in_valid = 1'b0;
    repeat (8) step();
    n_checks++; if (busy !== 1'b0) begin
      n_fail++; $display("FAIL midrst_resume: busy got %b expected 0", busy);
    end
  endtask

  task automatic test_len255();
    int n_acc;
    int n_rv;
    int n_done;
    int n_bad;
    logic acc_now;
    n_acc = 0; n_rv = 0; n_done = 0; n_bad = 0;
    start_run(8'd255, 16'h0000);
    for (int k = 0; k < 280; k++) begin
      x_in_valid = 1'b1; x_in = 16'h0100 + 16'(n_acc);
      acc_now = x_in_ready;
      step();
      if (acc_now === 1'b1) n_acc++;
      if (res_valid === 1'b1) begin
        if (res !== ((16'h0100 + 16'(n_rv)) ^ 16'h5A00)) n_bad++;
        n_rv++;
      end
      if (done === 1'b1) n_done++;
    end
    x_in_valid = 1'b0;
    n_checks++; if (n_acc != 255) begin
      n_fail++; $display("FAIL len255_accepts: got %0d expected 255", n_acc);
    end
    n_checks++; if (n_rv != 255) begin
      n_fail++; $display("FAIL len255_results: got %0d expected 255", n_rv);
    end
    n_checks++; if (n_done != 1) begin
      n_fail++; $display("FAIL len255_done: got %0d expected 1", n_done);
    end
    n_checks++; if (n_bad != 0) begin
      n_fail++; $display("FAIL len255_order: got %0d wrong results expected 0", n_bad);
    end
    n_checks++; if ({res, busy} !== {16'h5BFE, 1'b0}) begin
      n_fail++; $display("FAIL len255_final: got res=%h busy=%b expected res=5BFE busy=0", res, busy);
    end
  endtask

  initial begin
    test_reset();
    test_coef_load();
    test_streaming();
    test_gaps();
    test_illegal();
    test_reset_midrun();
    test_len255();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ring_sequencer.md
RING_SEQUENCER -- requirements
Module: ring_sequencer

Interface
REQ-001 The block SHALL take parameter N_PE, default 4, the number of processing elements in the systolic ring (2..16).
REQ-002 The block SHALL take parameter W, default 16, the data width of ring samples, coefficients and results.
REQ-003 The ports SHALL be, one per line, name  direction  width  meaning:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- coef_wr  in  1  write coefficient coef_data to slot coef_idx.
- coef_idx  in  clog2(N_PE)  coefficient slot.
- coef_data  in  W  coefficient value.
- seed  in  W  initial x value broadcast to the ring during LOAD.
- len  in  8  number of samples in a run; 0 is illegal.
- start  in  1  begin a run.
- x_in  in  W  input sample.
- x_in_valid  in  1  x_in is valid.
- x_in_ready  out  1  block accepts x_in this cycle.
- pe_clear  out  1  synchronous clear to the ring PEs.
- pe_load  out  1  ring latches a and x_init this cycle.
- a  out  W  coefficient to the PE being loaded.
- x_init  out  W  initial x to the PE being loaded.
- x  out  W  sample into the ring.
- y  in  W  ring output.
- res  out  W  captured result.
- res_valid  out  1  res valid, one-cycle pulse per result.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at run end.

Function
REQ-004 The FSM SHALL have states IDLE, CLEAR, LOAD, RUN, DRAIN, DONE.
REQ-005 In IDLE, coef_wr SHALL write coef_data into slot coef_idx at the clock edge; coef_wr outside IDLE SHALL be ignored.
REQ-006 start with len != 0 in IDLE SHALL latch len and seed and move to CLEAR; start with len == 0, or start outside IDLE, SHALL be ignored.
REQ-007 CLEAR SHALL last exactly 1 cycle with pe_clear=1, then move to LOAD.
REQ-008 LOAD SHALL last exactly N_PE cycles; in cycle k (0..N_PE-1) the block SHALL drive pe_load=1, a=coef[k] and x_init=latched seed.
REQ-009 After LOAD the FSM SHALL enter RUN.
REQ-010 In RUN, x_in_ready SHALL be 1; it SHALL be 0 in every other state.
REQ-011 A sample SHALL be accepted when x_in_valid && x_in_ready; it SHALL appear on x the next cycle.
REQ-012 x SHALL hold 0 in cycles with no accepted sample.
REQ-013 When the len-th sample is accepted, the FSM SHALL go to DRAIN.
REQ-014 Each accepted sample SHALL enter an N_PE-deep valid shift register.
REQ-015 When a tag exits the shift register (N_PE+1 cycles after acceptance), res SHALL take y and res_valid SHALL pulse for 1 cycle.
REQ-016 Gaps in x_in_valid SHALL propagate as gaps in res_valid; result order SHALL equal sample order.
REQ-017 DRAIN SHALL wait until the shift register is empty, then enter DONE.
REQ-018 DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-019 Exactly len res_valid pulses SHALL occur per run.
REQ-020 The sample counter SHALL be 8 bits with no wrap: a run with len=255 accepts exactly 255 samples.
REQ-021 res SHALL hold its last value between pulses.
REQ-022 pe_clear, pe_load and done SHALL be registered outputs.

Reset
REQ-023 While reset=0, the block SHALL asynchronously force: state IDLE; all outputs 0; coefficients 0; counters and shift register cleared.
REQ-024 Reset asserted mid-run SHALL abort the run with no done pulse and no further res_valid.
REQ-025 Operation SHALL resume on the first rising clk edge after reset returns to 1.

Verification
REQ-026 Coefficient load: N_PE=4; write coef = 1,2,3,4, seed=1, start with len=4 -> one pe_clear cycle, then 4 pe_load cycles with a=1,2,3,4 and x_init=1.
REQ-027 Streaming: continuous x_in=1,2,3,4 -> x=1,2,3,4 on consecutive cycles; res_valid pulses 5 cycles after each acceptance; done 1 cycle after the 4th result.
REQ-028 Backpressure/gaps: valid pattern 1,0,1,1,0,1 with len=4 -> the res_valid pattern is the same, shifted by 5 cycles; exactly 4 results.
REQ-029 Illegal/ignored: start with len=0 -> busy stays 0; coef_wr during RUN -> a on the next run is unchanged.
REQ-030 Reset mid-run: reset=0 after 2 of 4 samples -> all outputs are 0 immediately; the FSM is in IDLE and no done pulse occurs.
REQ-031 Boundary: len=255 -> exactly 255 accepts and 255 res_valid pulses, then one done pulse.
